pulse_frame_receiver: RTL and testbench
=======================================

PULSE_FRAME_RECEIVER -- requirements
Module: pulse_frame_receiver

Interface
REQ-001 Parameter WIDTH, default 30, number of bits per received word.
REQ-002 Parameter SLOT, default 27, length in Clock cycles of one pulse slot; legal range 4 to 255.
REQ-003 Parameter TIMEOUT, default 65536, number of idle cycles allowed between bits of a word.
REQ-004 The synchronous, active-high reset Rec_Reset SHALL be the only reset, and Clock the only clock.
REQ-005 Clock  input  1  system clock; all logic on the rising edge.
REQ-006 Rec_Reset  input  1  synchronous active-high reset.
REQ-007 Rec_en  input  1  receive enable; low holds the receiver idle.
REQ-008 Din  input  1  asynchronous serial line; the line idles high.
REQ-009 Dout  output  WIDTH  last complete word; the first received bit is in Dout[WIDTH-1].
REQ-010 OutValid  output  1  one-cycle pulse when Dout is updated.
REQ-011 Timeout  output  1  one-cycle pulse when a partial word is abandoned for inactivity.
REQ-012 FrameError  output  1  one-cycle pulse when a bad stop slot is sampled.
REQ-013 BitCount  output  $clog2(WIDTH+1)  number of bits accepted in the current word.

Function
REQ-014 Din SHALL pass through a 2-flop synchronizer, and all timing SHALL refer to the synchronized signal s.
REQ-015 Each bit cell SHALL be 4*SLOT cycles long:
- start slot: low, 1 slot
- data: 2 slots
- stop slot: high, 1 slot
REQ-016 The FSM SHALL have the states IDLE, START, DATA, STOP and WAIT, with a cycle counter cnt.
REQ-017 In IDLE or WAIT, a falling edge of s SHALL enter START with cnt=0.
REQ-018 At cnt=SLOT/2 (integer division), START SHALL go to DATA if s=0, or else return to the prior state (IDLE or WAIT) with no error.
REQ-019 At cnt=2*SLOT, DATA SHALL capture the data bit into the shift register and go to STOP.
REQ-020 At cnt=3*SLOT+SLOT/2, STOP SHALL check s.
- s=1: BitCount increments, then enter WAIT, or complete the word when BitCount reaches WIDTH.
- s=0: FrameError pulses, the partial word is discarded, BitCount goes to 0, and the FSM enters IDLE.
REQ-021 On word completion, Dout SHALL load the word and OutValid SHALL be 1 on the cycle after the stop sample; BitCount SHALL then go to 0 and the FSM SHALL enter IDLE.
REQ-022 WAIT SHALL count idle cycles from entry; on reaching TIMEOUT with no falling edge, Timeout SHALL pulse, the word SHALL be discarded, BitCount SHALL go to 0 and the FSM SHALL enter IDLE.
REQ-023 IDLE SHALL never time out.
REQ-024 Rec_en=0 SHALL force IDLE and clear the counters, the shift register and BitCount, with all pulses 0 and Dout held.
REQ-025 Rec_en=0 SHALL take priority over a completion, error or timeout in the same cycle.
REQ-026 OutValid, Timeout and FrameError SHALL be mutually exclusive and never wider than one cycle.
REQ-027 A falling edge during DATA or STOP SHALL be ignored, except through the value sampled.

Reset
REQ-028 While Rec_Reset=1 the following SHALL hold:
- FSM in IDLE
- Dout=0, BitCount=0
- OutValid=0, Timeout=0, FrameError=0
- counters and synchronizer cleared, with the synchronizer flops set to 1 (line idle)
REQ-029 Rec_Reset SHALL override Rec_en, and a reset in mid-word SHALL discard the word with no pulse.

Configuration
REQ-030 With RX_MAJORITY_EN defined, the data bit SHALL be the 2-of-3 majority of s sampled at cnt=2*SLOT-1, 2*SLOT and 2*SLOT+1, and the DATA state SHALL exit at 2*SLOT+1.
REQ-031 Without RX_MAJORITY_EN, only the single sample at cnt=2*SLOT SHALL be used, as in REQ-019.

Verification
REQ-032 WIDTH=30, SLOT=27: 20 cycles in reset, then 30 clean cells with bits 1,0,1 repeated -> one OutValid pulse, Dout=30'h2DB6DB6D, no other pulses.
REQ-033 WIDTH=30, TIMEOUT=1000: 5 clean cells, then Din held high for 1000+ cycles -> Timeout pulses once ~1000 cycles after the 5th stop sample, BitCount returns to 0, Dout unchanged.
REQ-034 A 5-cycle low glitch on idle Din -> no state change, BitCount=0, no pulses.
REQ-035 Cell 3 has its stop slot held low -> FrameError pulses once and BitCount=0; a following full clean 30-cell word is received correctly.
REQ-036 Rec_Reset=1 asserted for 1 cycle after bit 10 -> all outputs reset, no pulse; Rec_en=0 mid-word -> BitCount=0, Dout held.
REQ-037 With RX_MAJORITY_EN: a 1-cycle inverted glitch exactly at cnt=2*SLOT in a '1' cell -> bit received as 1; without the macro -> bit received as 0.

Source files
------------

// File: rtl/pulse_frame_receiver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pulse_frame_receiver: pulse-slot serial word receiver; RX_MAJORITY_EN    |
// | selects 2-of-3 data sampling.                          rev 1.0           |
// +--------------------------------------------------------------------------+
module pulse_frame_receiver #(
  parameter int WIDTH   = 30,
  parameter int SLOT    = 27,
  parameter int TIMEOUT = 65536
) (
  input  logic                       Clock,
  input  logic                       Rec_Reset,
  input  logic                       Rec_en,
  input  logic                       Din,
  output logic [WIDTH-1:0]           Dout,
  output logic                       OutValid,
  output logic                       Timeout,
  output logic                       FrameError,
  output logic [$clog2(WIDTH+1)-1:0] BitCount
);
  localparam int CW = $clog2(4*SLOT);
  localparam int TW = $clog2(TIMEOUT+1);
  localparam int BW = $clog2(WIDTH+1);

  localparam logic [CW-1:0] START_CHK = CW'(SLOT/2);
  localparam logic [CW-1:0] DATA_CHK  = CW'(2*SLOT);
  localparam logic [CW-1:0] STOP_CHK  = CW'(3*SLOT + SLOT/2);
  localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT-1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(WIDTH-1);
`ifdef RX_MAJORITY_EN
  localparam logic [CW-1:0] DATA_EARLY = CW'(2*SLOT-1);
  localparam logic [CW-1:0] DATA_LATE  = CW'(2*SLOT+1);
`endif

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;

  logic [1:0]       sync_q, sync_d;
  logic             s_prev_q, s_prev_d;
  logic [2:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic             ret_wait_q, ret_wait_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]    bit_count_q, bit_count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             out_valid_q, out_valid_d;
  logic             timeout_q, timeout_d;
  logic             frame_error_q, frame_error_d;
`ifdef RX_MAJORITY_EN
  logic [1:0]       maj_q, maj_d;
`endif

  logic s;
  logic fall;
  assign s    = sync_q[1];
  assign fall = s_prev_q & ~s;

  always_comb begin
    sync_d        = {sync_q[0], Din};
    s_prev_d      = s;
    state_d       = state_q;
    cnt_d         = cnt_q;
    tcnt_d        = tcnt_q;
    ret_wait_d    = ret_wait_q;
    shift_d       = shift_q;
    bit_count_d   = bit_count_q;
    dout_d        = dout_q;
    out_valid_d   = 1'b0;
    timeout_d     = 1'b0;
    frame_error_d = 1'b0;
`ifdef RX_MAJORITY_EN
    maj_d         = maj_q;
`endif
    if (!Rec_en) begin
      state_d     = S_IDLE;
      cnt_d       = '0;
      tcnt_d      = '0;
      ret_wait_d  = 1'b0;
      shift_d     = '0;
      bit_count_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (fall) begin
            state_d    = S_START;
            cnt_d      = '0;
            ret_wait_d = 1'b0;
          end
        end
        S_WAIT: begin
          if (fall) begin
            state_d    = S_START;
            cnt_d      = '0;
            ret_wait_d = 1'b1;
          end else if (tcnt_q == WAIT_LAST) begin
            timeout_d   = 1'b1;
            shift_d     = '0;
            bit_count_d = '0;
            tcnt_d      = '0;
            state_d     = S_IDLE;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
        S_START: begin
          cnt_d = cnt_q + 1'b1;
          // A start pulse that is gone by mid-slot was a glitch: resume where we were.
          if (cnt_q == START_CHK) begin
            if (!s) state_d = S_DATA;
            else    state_d = ret_wait_q ? S_WAIT : S_IDLE;
          end
        end
        S_DATA: begin
          cnt_d = cnt_q + 1'b1;
`ifdef RX_MAJORITY_EN
          if (cnt_q == DATA_EARLY) maj_d[0] = s;
          if (cnt_q == DATA_CHK)   maj_d[1] = s;
          if (cnt_q == DATA_LATE) begin
            shift_d = {shift_q[WIDTH-2:0],
                       (maj_q[0] & maj_q[1]) | (maj_q[0] & s) | (maj_q[1] & s)};
            state_d = S_STOP;
          end
`else
          if (cnt_q == DATA_CHK) begin
            shift_d = {shift_q[WIDTH-2:0], s};
            state_d = S_STOP;
          end
`endif
        end
        S_STOP: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == STOP_CHK) begin
            cnt_d = '0;
            if (s && (bit_count_q == LAST_BIT)) begin
              dout_d      = shift_q;
              out_valid_d = 1'b1;
              shift_d     = '0;
              bit_count_d = '0;
              state_d     = S_IDLE;
            end else if (s) begin
              bit_count_d = bit_count_q + 1'b1;
              tcnt_d      = '0;
              state_d     = S_WAIT;
            end else begin
              frame_error_d = 1'b1;
              shift_d       = '0;
              bit_count_d   = '0;
              state_d       = S_IDLE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Rec_Reset) begin
      sync_q        <= 2'b11;
      s_prev_q      <= 1'b1;
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      tcnt_q        <= '0;
      ret_wait_q    <= 1'b0;
      shift_q       <= '0;
      bit_count_q   <= '0;
      dout_q        <= '0;
      out_valid_q   <= 1'b0;
      timeout_q     <= 1'b0;
      frame_error_q <= 1'b0;
`ifdef RX_MAJORITY_EN
      maj_q         <= 2'b00;
`endif
    end else begin
      sync_q        <= sync_d;
      s_prev_q      <= s_prev_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      tcnt_q        <= tcnt_d;
      ret_wait_q    <= ret_wait_d;
      shift_q       <= shift_d;
      bit_count_q   <= bit_count_d;
      dout_q        <= dout_d;
      out_valid_q   <= out_valid_d;
      timeout_q     <= timeout_d;
      frame_error_q <= frame_error_d;
`ifdef RX_MAJORITY_EN
      maj_q         <= maj_d;
`endif
    end
  end

  assign Dout       = dout_q;
  assign OutValid   = out_valid_q;
  assign Timeout    = timeout_q;
  assign FrameError = frame_error_q;
  assign BitCount   = bit_count_q;

endmodule
`default_nettype wire

// File: tb/tb_pulse_frame_receiver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pulse_frame_receiver: directed/random bench for pulse_frame_receiver. |
// |                                                        rev 1.0           |
// +--------------------------------------------------------------------------+
module tb_pulse_frame_receiver;
  localparam int WIDTH   = 30;
  localparam int SLOT    = 27;
  localparam int TIMEOUT = 1000;
  localparam int CELL    = 4*SLOT;

  logic             Clock = 1'b0;
  logic             Rec_Reset;
  logic             Rec_en;
  logic             Din;
  logic [WIDTH-1:0] Dout;
  logic             OutValid;
  logic             Timeout;
  logic             FrameError;
  logic [4:0]       BitCount;

  int total = 0;
  int bad   = 0;

  // Event monitor: counts each pulse cycle and flags overlaps or stretched pulses.
  int   n_ov = 0, n_to = 0, n_fe = 0, n_clash = 0;
  logic p_ov = 1'b0, p_to = 1'b0, p_fe = 1'b0;

  pulse_frame_receiver #(
    .WIDTH   (WIDTH),
    .SLOT    (SLOT),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .Clock      (Clock),
    .Rec_Reset  (Rec_Reset),
    .Rec_en     (Rec_en),
    .Din        (Din),
    .Dout       (Dout),
    .OutValid   (OutValid),
    .Timeout    (Timeout),
    .FrameError (FrameError),
    .BitCount   (BitCount)
  );

  always #5 Clock = ~Clock;

  always @(negedge Clock) begin
    if (OutValid)   n_ov = n_ov + 1;
    if (Timeout)    n_to = n_to + 1;
    if (FrameError) n_fe = n_fe + 1;
    if ((32'(OutValid) + 32'(Timeout) + 32'(FrameError)) > 1) n_clash = n_clash + 1;
    if ((OutValid && p_ov) || (Timeout && p_to) || (FrameError && p_fe)) n_clash = n_clash + 1;
    p_ov = OutValid;
    p_to = Timeout;
    p_fe = FrameError;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total = total + 1;
    assert (obs === expv) else begin
      bad = bad + 1;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic idle(input int n);
    Din = 1'b1;
    repeat (n) @(negedge Clock);
  endtask

  // One bit cell; glitch inverts the single cycle the centre data sample sees.
  task automatic send_cell(input logic b, input logic stop_ok, input logic glitch);
    logic v;
    for (int t = 0; t < CELL; t++) begin
      if (t < SLOT)          v = 1'b0;
      else if (t < 3*SLOT)   v = b;
      else                   v = stop_ok;
      if (glitch && t == 2*SLOT + 1) v = ~v;
      Din = v;
      @(negedge Clock);
    end
  endtask

  // Sends word bits MSB first, optionally glitching cell gidx.
  task automatic send_word(input logic [WIDTH-1:0] w, input int gidx);
    for (int i = 0; i < WIDTH; i++)
      send_cell(w[WIDTH-1-i], 1'b1, i == gidx);
  endtask

  function automatic logic [WIDTH-1:0] rand_word();
    logic [31:0] r;
    r = $urandom;
    return r[WIDTH-1:0];
  endfunction

  initial begin
    logic [WIDTH-1:0] w;
    logic [WIDTH-1:0] exp_dout;
    logic             gbit;
    int               exp_ov, exp_to, exp_fe;
    exp_ov = 0; exp_to = 0; exp_fe = 0;
    exp_dout = '0;

    Din = 1'b1; Rec_en = 1'b1; Rec_Reset = 1'b1;
    repeat (20) @(negedge Clock);
    chk("reset_dout",     32'(Dout), 32'(exp_dout));
    chk("reset_bitcount", 32'(BitCount), 32'd0);
    chk("reset_outvalid", 32'(OutValid), 32'd0);
    chk("reset_timeout",  32'(Timeout), 32'd0);
    chk("reset_frameerr", 32'(FrameError), 32'd0);
    Rec_Reset = 1'b0;
    idle(10);

    // Word of repeating 1,0,1 bits
    for (int i = 0; i < WIDTH; i++) w[WIDTH-1-i] = ((i % 3) != 1);
    send_word(w, -1);
    idle(10);
    exp_ov++; exp_dout = w;
    chk("pat101_ov",   32'(n_ov), 32'(exp_ov));
    chk("pat101_dout", 32'(Dout), 32'h2DB6DB6D);
    chk("pat101_to",   32'(n_to), 32'(exp_to));
    chk("pat101_fe",   32'(n_fe), 32'(exp_fe));

    // Short low glitch on the idle line
    Din = 1'b0;
    repeat (5) @(negedge Clock);
    idle(60);
    chk("glitch_bitcount", 32'(BitCount), 32'd0);
    chk("glitch_pulses",   32'(n_ov + n_to + n_fe), 32'(exp_ov + exp_to + exp_fe));

    // Partial word followed by inactivity
    w = rand_word();
    for (int i = 0; i < 5; i++) send_cell(w[i], 1'b1, 1'b0);
    Din = 1'b1;
    chk("to_bitcount5", 32'(BitCount), 32'd5);
    idle(900);
    chk("to_not_yet", 32'(n_to), 32'(exp_to));
    idle(200);
    exp_to++;
    chk("to_pulse",    32'(n_to), 32'(exp_to));
    chk("to_bitcount", 32'(BitCount), 32'd0);
    chk("to_dout",     32'(Dout), 32'(exp_dout));
    chk("to_ov",       32'(n_ov), 32'(exp_ov));

    // Bad stop slot on cell 3, then a clean word
    send_cell($urandom_range(0, 1) == 1, 1'b1, 1'b0);
    send_cell($urandom_range(0, 1) == 1, 1'b1, 1'b0);
    send_cell($urandom_range(0, 1) == 1, 1'b0, 1'b0);
    idle(20);
    exp_fe++;
    chk("fe_pulse",    32'(n_fe), 32'(exp_fe));
    chk("fe_bitcount", 32'(BitCount), 32'd0);
    chk("fe_ov",       32'(n_ov), 32'(exp_ov));
    w = rand_word();
    send_word(w, -1);
    idle(10);
    exp_ov++; exp_dout = w;
    chk("fe_next_ov",   32'(n_ov), 32'(exp_ov));
    chk("fe_next_dout", 32'(Dout), 32'(exp_dout));

    // Random words
    for (int k = 0; k < 2; k++) begin
      w = rand_word();
      send_word(w, -1);
      idle($urandom_range(3, 40));
      exp_ov++; exp_dout = w;
      chk("rand_ov",   32'(n_ov), 32'(exp_ov));
      chk("rand_dout", 32'(Dout), 32'(exp_dout));
    end

    // Centre-sample glitch inside a '1' cell (cell 7)
    w = rand_word();
    w[WIDTH-1-7] = 1'b1;
`ifdef RX_MAJORITY_EN
    gbit = 1'b1;
`else
    gbit = 1'b0;
`endif
    send_word(w, 7);
    idle(10);
    exp_ov++;
    exp_dout = w;
    exp_dout[WIDTH-1-7] = gbit;
    chk("maj_ov",   32'(n_ov), 32'(exp_ov));
    chk("maj_dout", 32'(Dout), 32'(exp_dout));

    // Reset after bit 10
    w = rand_word();
    for (int i = 0; i < 10; i++) send_cell(w[i], 1'b1, 1'b0);
    Rec_Reset = 1'b1;
    @(negedge Clock);
    Rec_Reset = 1'b0;
    exp_dout = '0;
    chk("mid_rst_dout",     32'(Dout), 32'(exp_dout));
    chk("mid_rst_bitcount", 32'(BitCount), 32'd0);
    idle(200);
    chk("mid_rst_pulses", 32'(n_ov + n_to + n_fe), 32'(exp_ov + exp_to + exp_fe));

    w = rand_word();
    send_word(w, -1);
    idle(10);
    exp_ov++; exp_dout = w;
    chk("post_rst_dout", 32'(Dout), 32'(exp_dout));

    // Receiver disabled mid-word
    w = rand_word();
    for (int i = 0; i < 4; i++) send_cell(w[i], 1'b1, 1'b0);
    chk("en_bitcount4", 32'(BitCount), 32'd4);
    Rec_en = 1'b0;
    @(negedge Clock);
    chk("en_bitcount0", 32'(BitCount), 32'd0);
    chk("en_dout_held", 32'(Dout), 32'(exp_dout));
    idle(1200);
    chk("en_pulses", 32'(n_ov + n_to + n_fe), 32'(exp_ov + exp_to + exp_fe));
    Rec_en = 1'b1;
    idle(5);
    w = rand_word();
    send_word(w, -1);
    idle(10);
    exp_ov++; exp_dout = w;
    chk("en_after_ov",   32'(n_ov), 32'(exp_ov));
    chk("en_after_dout", 32'(Dout), 32'(exp_dout));

    chk("pulse_exclusive", 32'(n_clash), 32'd0);
    chk("final_to", 32'(n_to), 32'(exp_to));
    chk("final_fe", 32'(n_fe), 32'(exp_fe));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
